// File: rtl/serial_pixel_packer_if.sv
// Bus bundle between the serial pixel packer, the serial receiver and the SDRAM controller.
// The master modport is the packer's view; the slave modport is the receiver/controller view.
interface serial_pixel_packer_if #(
    parameter int AW      = 25,
    parameter int FIFO_AW = 2
);
    logic              sr_data_rdy;
    logic [7:0]        sr_data;
    logic              rd_busy;
    logic              wr_req;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       wr_data;
    logic              mem_ack;
    logic              wr_data_next;
    logic [FIFO_AW:0]  fifo_level;
    logic              frame_done;
    logic              overflow;

    modport master (
        input  sr_data_rdy, sr_data, rd_busy, mem_ack, wr_data_next,
        output wr_req, wr_addr, wr_data, fifo_level, frame_done, overflow
    );

    modport slave (
        output sr_data_rdy, sr_data, rd_busy, mem_ack, wr_data_next,
        input  wr_req, wr_addr, wr_data, fifo_level, frame_done, overflow
    );
endinterface

// File: rtl/serial_pixel_packer.sv
// Packs serial bytes into 32-bit pixel-pair words, buffers them and issues single-word SDRAM writes.
// Optional idle-timeout frame resync is enabled by defining SERIAL_RESYNC_EN.
module serial_pixel_packer #(
    parameter int AW          = 25,
    parameter int FIFO_AW     = 2,
    parameter int BASE_ADDR   = 0,
    parameter int FRAME_WORDS = 240000,
    parameter int TIMEOUT     = 800000
) (
    input  logic                   mem_clk,
    input  logic                   reset,
    serial_pixel_packer_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] LEVEL_ZERO = {(FIFO_AW + 1){1'b0}};
    localparam logic [AW-1:0]    ADDR_FIRST = AW'(BASE_ADDR);
    localparam logic [AW-1:0]    ADDR_LAST  = AW'(BASE_ADDR + FRAME_WORDS - 1);

    state_e               state_q;
    logic                 wr_req_q;
    logic [AW-1:0]        wr_addr_q;
    logic [31:0]          wr_data_q;
    logic                 frame_done_q;
    logic                 overflow_q;

    logic [1:0]           byte_idx_q;
    logic [23:0]          partial_q;
    logic                 push_pend_q;
    logic [31:0]          push_word_q;

    logic [31:0]          mem_q [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q;
    logic [FIFO_AW-1:0]   rd_ptr_q;
    logic [FIFO_AW:0]     level_q;

    logic                 pop_s;
    logic                 push_ok_s;
    logic                 timeout_s;
    logic                 resync_pending_s;

    assign pop_s     = (state_q == ST_DATA) && bus.wr_data_next;
    // A full FIFO still takes the word when the head leaves in the same cycle.
    assign push_ok_s = push_pend_q && ((level_q < LEVEL_FULL) || pop_s);

`ifdef SERIAL_RESYNC_EN
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] idle_cnt_q;
    logic             resync_q;

    assign timeout_s        = ~bus.sr_data_rdy && (idle_cnt_q == CNT_LAST);
    assign resync_pending_s = resync_q;

    // Idle counter saturates so a long pause raises the resync flag only once.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            idle_cnt_q <= {CNT_W{1'b0}};
            resync_q   <= 1'b0;
        end else begin
            if (bus.sr_data_rdy) begin
                idle_cnt_q <= {CNT_W{1'b0}};
            end else if (idle_cnt_q != CNT_SAT) begin
                idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end else begin
                idle_cnt_q <= idle_cnt_q;
            end
            if (timeout_s) begin
                resync_q <= 1'b1;
            end else if ((state_q == ST_IDLE) && (level_q == LEVEL_ZERO)) begin
                resync_q <= 1'b0;
            end else begin
                resync_q <= resync_q;
            end
        end
    end
`else
    assign timeout_s        = 1'b0;
    assign resync_pending_s = 1'b0;
`endif

    // Byte assembler: MSB-first, completed word is offered to the FIFO one cycle later.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            byte_idx_q  <= 2'd0;
            partial_q   <= 24'h000000;
            push_pend_q <= 1'b0;
            push_word_q <= 32'h00000000;
        end else begin
            push_pend_q <= 1'b0;
            if (bus.sr_data_rdy) begin
                if (byte_idx_q == 2'd3) begin
                    push_pend_q <= 1'b1;
                    push_word_q <= {partial_q, bus.sr_data};
                    byte_idx_q  <= 2'd0;
                end else begin
                    partial_q  <= {partial_q[15:0], bus.sr_data};
                    byte_idx_q <= byte_idx_q + 2'd1;
                end
            end else if (timeout_s) begin
                byte_idx_q <= 2'd0;
            end else begin
                byte_idx_q <= byte_idx_q;
            end
        end
    end

    // Word storage, written only when the push is accepted.
    always_ff @(posedge mem_clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_word_q;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            wr_ptr_q   <= {FIFO_AW{1'b0}};
            rd_ptr_q   <= {FIFO_AW{1'b0}};
            level_q    <= LEVEL_ZERO;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
            end
            if (push_ok_s && !pop_s) begin
                level_q <= level_q + (FIFO_AW + 1)'(1);
            end else if (pop_s && !push_ok_s) begin
                level_q <= level_q - (FIFO_AW + 1)'(1);
            end else begin
                level_q <= level_q;
            end
            if (push_pend_q && !push_ok_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Request FSM with registered request, address, data and frame pulse.
    always_ff @(posedge mem_clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= ADDR_FIRST;
            wr_data_q    <= 32'h00000000;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (level_q != LEVEL_ZERO) begin
                        state_q   <= ST_REQ;
                        wr_req_q  <= ~bus.rd_busy;
                        wr_data_q <= mem_q[rd_ptr_q];
                    end else if (resync_pending_s) begin
                        wr_addr_q <= ADDR_FIRST;
                    end else begin
                        wr_req_q <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (wr_req_q && bus.mem_ack) begin
                        state_q  <= ST_DATA;
                        wr_req_q <= 1'b0;
                    end else begin
                        wr_req_q <= ~bus.rd_busy;
                    end
                end
                ST_DATA: begin
                    wr_req_q <= 1'b0;
                    if (bus.wr_data_next) begin
                        state_q <= ST_IDLE;
                        if (wr_addr_q == ADDR_LAST) begin
                            wr_addr_q    <= ADDR_FIRST;
                            frame_done_q <= 1'b1;
                        end else begin
                            wr_addr_q <= wr_addr_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    wr_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_req     = wr_req_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.fifo_level = level_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_serial_pixel_packer.sv
// Directed bench for serial_pixel_packer: small frame (8 words) so the wrap is reachable quickly.
module tb_serial_pixel_packer;

    localparam int AW      = 25;
    localparam int FIFO_AW = 2;

    logic mem_clk = 1'b0;
    logic reset   = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    serial_pixel_packer_if #(.AW(AW), .FIFO_AW(FIFO_AW)) bus ();

    serial_pixel_packer #(
        .AW(AW), .FIFO_AW(FIFO_AW), .BASE_ADDR(0), .FRAME_WORDS(8), .TIMEOUT(100)
    ) dut (
        .mem_clk (mem_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mem_clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.sr_data_rdy = 1'b1;
        bus.sr_data     = b;
        cyc(1);
        bus.sr_data_rdy = 1'b0;
        bus.sr_data     = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.wr_req !== 1'b1 && n < 100) begin
            cyc(1);
            n++;
        end
        chk(tag, {63'd0, bus.wr_req}, 64'd1);
    endtask

    // Acts as the controller for one write; reports frame_done as seen right after the pop.
    task automatic do_write(input string tag, input logic [AW-1:0] exp_addr,
                            input logic [31:0] exp_data, output logic fd);
        wait_req({tag, "_req"});
        chk({tag, "_addr"}, 64'(bus.wr_addr), 64'(exp_addr));
        chk({tag, "_data"}, 64'(bus.wr_data), 64'(exp_data));
        bus.mem_ack = 1'b1;
        cyc(1);
        bus.mem_ack = 1'b0;
        chk({tag, "_req_drop"}, {63'd0, bus.wr_req}, 64'd0);
        cyc(1);
        bus.wr_data_next = 1'b1;
        cyc(1);
        bus.wr_data_next = 1'b0;
        fd = bus.frame_done;
    endtask

    initial begin
        logic fd;
        int   hi;
        bus.sr_data_rdy  = 1'b0;
        bus.sr_data      = 8'h00;
        bus.rd_busy      = 1'b0;
        bus.mem_ack      = 1'b0;
        bus.wr_data_next = 1'b0;

        // Reset state
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("rst_req",   {63'd0, bus.wr_req}, 64'd0);
        chk("rst_addr",  64'(bus.wr_addr), 64'd0);
        chk("rst_data",  64'(bus.wr_data), 64'd0);
        chk("rst_level", 64'(bus.fifo_level), 64'd0);
        chk("rst_fd",    {63'd0, bus.frame_done}, 64'd0);
        chk("rst_ovf",   {63'd0, bus.overflow}, 64'd0);

        // 1: single word, MSB-first packing
        send_word(32'hF80007E0);
        do_write("t1", 25'd0, 32'hF80007E0, fd);
        chk("t1_fd", {63'd0, fd}, 64'd0);
        cyc(1);
        chk("t1_addr_next", 64'(bus.wr_addr), 64'd1);
        chk("t1_level",     64'(bus.fifo_level), 64'd0);

        // 2: read priority holds off the request
        bus.rd_busy = 1'b1;
        send_word(32'h12345678);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (bus.wr_req === 1'b1) hi++;
        end
        chk("t2_busy_req_cycles", 64'(hi), 64'd0);
        chk("t2_busy_level", 64'(bus.fifo_level), 64'd1);
        bus.rd_busy = 1'b0;
        do_write("t2", 25'd1, 32'h12345678, fd);

        // 3: stalled controller, overflow after four buffered words
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'h44444444);
        send_word(32'h55555555);
        send_word(32'h66666666);
        cyc(3);
        chk("t3_level", 64'(bus.fifo_level), 64'd4);
        chk("t3_ovf",   {63'd0, bus.overflow}, 64'd1);
        do_write("t3w0", 25'd2, 32'h11111111, fd);
        do_write("t3w1", 25'd3, 32'h22222222, fd);
        do_write("t3w2", 25'd4, 32'h33333333, fd);
        do_write("t3w3", 25'd5, 32'h44444444, fd);
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.wr_req === 1'b1) hi++;
        end
        chk("t3_no_extra_req", 64'(hi), 64'd0);
        chk("t3_level_empty",  64'(bus.fifo_level), 64'd0);
        chk("t3_ovf_sticky",   {63'd0, bus.overflow}, 64'd1);

        // 4: frame wrap at 8 words
        send_word(32'hA0000006);
        do_write("t4w6", 25'd6, 32'hA0000006, fd);
        chk("t4_fd6", {63'd0, fd}, 64'd0);
        send_word(32'hA0000007);
        do_write("t4w7", 25'd7, 32'hA0000007, fd);
        chk("t4_fd7", {63'd0, fd}, 64'd1);
        chk("t4_wrap_addr", 64'(bus.wr_addr), 64'd0);
        cyc(1);
        chk("t4_fd_pulse_end", {63'd0, bus.frame_done}, 64'd0);
        send_word(32'hA0000000);
        do_write("t4w0", 25'd0, 32'hA0000000, fd);
        chk("t4_fd0", {63'd0, fd}, 64'd0);

        // 6: reset while in DATA discards FIFO and partial word
        send_word(32'hB0000001);
        send_word(32'hB0000002);
        send_byte(8'hEE);
        wait_req("t6_req");
        bus.mem_ack = 1'b1;
        cyc(1);
        bus.mem_ack = 1'b0;
        chk("t6_pre_level", 64'(bus.fifo_level), 64'd2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("t6_req",   {63'd0, bus.wr_req}, 64'd0);
        chk("t6_level", 64'(bus.fifo_level), 64'd0);
        chk("t6_addr",  64'(bus.wr_addr), 64'd0);
        chk("t6_ovf",   {63'd0, bus.overflow}, 64'd0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.wr_req === 1'b1) hi++;
        end
        chk("t6_no_req", 64'(hi), 64'd0);
        send_word(32'h9ABCDEF0);
        do_write("t6w", 25'd0, 32'h9ABCDEF0, fd);

`ifdef SERIAL_RESYNC_EN
        // 5: idle pause restarts the frame and drops the partial word
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        send_word(32'h01020304);
        send_byte(8'hCC);
        send_byte(8'hDD);
        do_write("t5w0", 25'd0, 32'h01020304, fd);
        cyc(150);
        send_word(32'hAABBCCDD);
        do_write("t5w1", 25'd0, 32'hAABBCCDD, fd);
        chk("t5_fd", {63'd0, fd}, 64'd0);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (bus.wr_req === 1'b1) hi++;
        end
        chk("t5_no_extra_req", 64'(hi), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
